// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the Ascon permutation engine.
package ascon_pkg;

  localparam int unsigned ASCON_MAX_ROUNDS = 12;

  // Right-rotation amounts of the linear diffusion layer, per state word.
  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  // Ascon 5-bit S-box; column value is {x0,x1,x2,x3,x4} with x0 as MSB.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Element [0] is x0, element [4] is x4.
  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] rc(input logic [3:0] k);
    rc = {4'd15 - k, k};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    ror64 = (x >> n) | (x << (64 - n));
  endfunction

  function automatic ascon_state_t LINEAR_DIFFUSION(input ascon_state_t s);
    ascon_state_t d;
    d[0] = s[0] ^ ror64(s[0], ROT_X0_A) ^ ror64(s[0], ROT_X0_B);
    d[1] = s[1] ^ ror64(s[1], ROT_X1_A) ^ ror64(s[1], ROT_X1_B);
    d[2] = s[2] ^ ror64(s[2], ROT_X2_A) ^ ror64(s[2], ROT_X2_B);
    d[3] = s[3] ^ ror64(s[3], ROT_X3_A) ^ ror64(s[3], ROT_X3_B);
    d[4] = s[4] ^ ror64(s[4], ROT_X4_A) ^ ror64(s[4], ROT_X4_B);
    LINEAR_DIFFUSION = d;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear
// diffusion. With i_en low the state passes through untouched.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [63:0] i_x0,
  input  logic [63:0] i_x1,
  input  logic [63:0] i_x2,
  input  logic [63:0] i_x3,
  input  logic [63:0] i_x4,
  input  logic [3:0]  i_k,
  input  logic        i_en,
  output logic [63:0] o_x0,
  output logic [63:0] o_x1,
  output logic [63:0] o_x2,
  output logic [63:0] o_x3,
  output logic [63:0] o_x4
);

  ascon_state_t w_in;
  ascon_state_t w_add;
  ascon_state_t w_sub;
  ascon_state_t w_lin;
  ascon_state_t w_out;

  assign w_in = {i_x4, i_x3, i_x2, i_x1, i_x0};

  // Round constant goes into the low byte of x2.
  always_comb begin
    w_add = w_in;
    w_add[2][7:0] = w_in[2][7:0] ^ rc(i_k);
  end

  // S-box applied to each of the 64 bit columns.
  always_comb begin
    logic [4:0] w_col;
    w_sub = '0;
    w_col = '0;
    for (int unsigned b = 0; b < 64; b++) begin
      w_col = SBOX[{w_add[0][b], w_add[1][b], w_add[2][b], w_add[3][b], w_add[4][b]}];
      w_sub[0][b] = w_col[4];
      w_sub[1][b] = w_col[3];
      w_sub[2][b] = w_col[2];
      w_sub[3][b] = w_col[1];
      w_sub[4][b] = w_col[0];
    end
  end

  assign w_lin = LINEAR_DIFFUSION(w_sub);
  assign w_out = i_en ? w_lin : w_in;

  assign o_x0 = w_out[0];
  assign o_x1 = w_out[1];
  assign o_x2 = w_out[2];
  assign o_x3 = w_out[3];
  assign o_x4 = w_out[4];

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon permutation p^R with UNROLL chained rounds per clock and
// valid/ready handshakes on both sides.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rnd,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_err,
  output logic [63:0] out_x0,
  output logic [63:0] out_x1,
  output logic [63:0] out_x2,
  output logic [63:0] out_x3,
  output logic [63:0] out_x4,
  output logic        busy
);

  state_e       r_state;
  state_e       w_next;
  ascon_state_t r_s;
  logic [3:0]   r_k;
  logic [3:0]   r_rem;
  logic         r_err;

  logic         w_accept;
  logic         w_illegal;
  logic [3:0]   w_n;

  logic [63:0]  w_x0 [UNROLL+1];
  logic [63:0]  w_x1 [UNROLL+1];
  logic [63:0]  w_x2 [UNROLL+1];
  logic [63:0]  w_x3 [UNROLL+1];
  logic [63:0]  w_x4 [UNROLL+1];
  logic [UNROLL-1:0] w_en;

  assign w_illegal = (in_rnd == 4'd0) || (in_rnd > 4'(ASCON_MAX_ROUNDS));

  // Rounds applied this cycle: min(UNROLL, remaining). An illegal request
  // enters BUSY with remaining=0, so every stage bypasses and the state
  // reaches DONE unchanged one cycle later.
  assign w_n = (r_rem > 4'(UNROLL)) ? 4'(UNROLL) : r_rem;

  assign w_x0[0] = r_s[0];
  assign w_x1[0] = r_s[1];
  assign w_x2[0] = r_s[2];
  assign w_x3[0] = r_s[3];
  assign w_x4[0] = r_s[4];

  for (genvar g = 0; g < int'(UNROLL); g++) begin : g_stage
    assign w_en[g] = (4'(g) < r_rem);
    ascon_round u_round (
      .i_x0 (w_x0[g]),
      .i_x1 (w_x1[g]),
      .i_x2 (w_x2[g]),
      .i_x3 (w_x3[g]),
      .i_x4 (w_x4[g]),
      .i_k  (r_k + 4'(g)),
      .i_en (w_en[g]),
      .o_x0 (w_x0[g+1]),
      .o_x1 (w_x1[g+1]),
      .o_x2 (w_x2[g+1]),
      .o_x3 (w_x3[g+1]),
      .o_x4 (w_x4[g+1])
    );
  end

  // Next-state and request-acceptance decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_rem == w_n) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = ST_BUSY;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, round counters and permutation state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_s   <= {in_x4, in_x3, in_x2, in_x1, in_x0};
        r_err <= w_illegal;
        r_k   <= w_illegal ? 4'd0 : 4'(ASCON_MAX_ROUNDS) - in_rnd;
        r_rem <= w_illegal ? 4'd0 : in_rnd;
      end else if (r_state == ST_BUSY) begin
        r_s   <= {w_x4[UNROLL], w_x3[UNROLL], w_x2[UNROLL], w_x1[UNROLL], w_x0[UNROLL]};
        r_k   <= r_k + w_n;
        r_rem <= r_rem - w_n;
      end else if ((r_state == ST_DONE) && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign out_err   = r_err;
  assign out_x0    = r_s[0];
  assign out_x1    = r_s[1];
  assign out_x2    = r_s[2];
  assign out_x3    = r_s[3];
  assign out_x4    = r_s[4];

endmodule

// File: tb/tb_ascon_perm_core.sv
// Five cores (UNROLL = 1,2,3,4,6) share stimulus; each is checked against a
// boolean-equation Ascon model for result, error flag and latency.
module tb_ascon_perm_core;

  localparam int NDUT = 5;
  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_rnd;
  st_t        in_s;
  logic       out_ready;

  logic        in_ready  [NDUT];
  logic        out_valid [NDUT];
  logic        out_err   [NDUT];
  logic        busy      [NDUT];
  logic [63:0] ox0 [NDUT];
  logic [63:0] ox1 [NDUT];
  logic [63:0] ox2 [NDUT];
  logic [63:0] ox3 [NDUT];
  logic [63:0] ox4 [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned UL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 6;
    ascon_perm_core #(.UNROLL(UL)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_rnd    (in_rnd),
      .in_x0     (in_s[0]),
      .in_x1     (in_s[1]),
      .in_x2     (in_s[2]),
      .in_x3     (in_s[3]),
      .in_x4     (in_s[4]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_err   (out_err[g]),
      .out_x0    (ox0[g]),
      .out_x1    (ox1[g]),
      .out_x2    (ox2[g]),
      .out_x3    (ox3[g]),
      .out_x4    (ox4[g]),
      .busy      (busy[g])
    );
  end

  int passed = 0;
  int total  = 0;

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 3 : (d == 3) ? 4 : 6;
  endfunction

  function automatic st_t dut_out(input int d);
    return {ox4[d], ox3[d], ox2[d], ox1[d], ox0[d]};
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t model_round(input st_t s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic st_t model_perm(input st_t s, input int r);
    st_t t = s;
    if (r < 1 || r > 12) return t;
    for (int i = 12 - r; i < 12; i++) t = model_round(t, i);
    return t;
  endfunction

  function automatic int model_lat(input int r, input int u);
    if (r < 1 || r > 12) return 1;
    return (r + u - 1) / u;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request to all cores; optionally release the previous result
  // in the same cycle.
  task automatic send(input logic [3:0] r, input st_t s, input bit with_release);
    @(negedge clk);
    in_valid = 1'b1;
    in_rnd   = r;
    in_s     = s;
    if (with_release) out_ready = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) chk($sformatf("in_ready_accept_u%0d", unroll_of(d)), 320'(in_ready[d]), 320'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_s      = rand_state();
    in_rnd    = 4'($urandom_range(0, 15));
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("busy_after_accept_u%0d", unroll_of(d)), 320'(busy[d]), 320'd1);
      chk($sformatf("no_valid_after_accept_u%0d", unroll_of(d)), 320'(out_valid[d]), 320'd0);
    end
  endtask

  // Wait (bounded) for every core's result, then check latency, data, err.
  task automatic collect(input logic [3:0] r, input st_t s, input bit do_release);
    int   lat [NDUT];
    int   ndone;
    st_t  exp_s;
    for (int d = 0; d < NDUT; d++) lat[d] = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      ndone = 0;
      for (int d = 0; d < NDUT; d++) begin
        if (out_valid[d] && lat[d] == 0) lat[d] = c;
        if (lat[d] != 0) ndone++;
      end
      if (ndone == NDUT) break;
    end
    exp_s = model_perm(s, int'(r));
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("latency_r%0d_u%0d", r, unroll_of(d)), 320'(lat[d]), 320'(model_lat(int'(r), unroll_of(d))));
      chk($sformatf("result_r%0d_u%0d", r, unroll_of(d)), dut_out(d), exp_s);
      chk($sformatf("err_r%0d_u%0d", r, unroll_of(d)), 320'(out_err[d]), 320'((r == 0 || r > 12) ? 1 : 0));
    end
    if (do_release) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("released_valid_u%0d", unroll_of(d)), 320'(out_valid[d]), 320'd0);
        chk($sformatf("released_ready_u%0d", unroll_of(d)), 320'(in_ready[d]), 320'd1);
        chk($sformatf("released_err_u%0d", unroll_of(d)), 320'(out_err[d]), 320'd0);
      end
    end
  endtask

  initial begin
    st_t        s, s2, exp_s;
    logic [3:0] r, r2;
    bit         stale [NDUT];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rnd = '0; in_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_in_ready_u%0d", unroll_of(d)), 320'(in_ready[d]), 320'd1);
      chk($sformatf("rst_out_valid_u%0d", unroll_of(d)), 320'(out_valid[d]), 320'd0);
      chk($sformatf("rst_err_u%0d", unroll_of(d)), 320'(out_err[d]), 320'd0);
      chk($sformatf("rst_busy_u%0d", unroll_of(d)), 320'(busy[d]), 320'd0);
      chk($sformatf("rst_state_u%0d", unroll_of(d)), dut_out(d), 320'd0);
    end
    rst_n = 1'b1;

    // p1 on the all-zero state
    s = '0;
    send(4'd1, s, 1'b0);
    collect(4'd1, s, 1'b1);

    // p12 on the reference initial-state pattern
    s = '0;
    s[0] = 64'h80400c0600000000;
    send(4'd12, s, 1'b0);
    collect(4'd12, s, 1'b1);

    // p6 on a random state (first constant 0x96)
    s = rand_state();
    send(4'd6, s, 1'b0);
    collect(4'd6, s, 1'b1);

    // illegal round counts pass the state through
    s = rand_state();
    send(4'd0, s, 1'b0);
    collect(4'd0, s, 1'b1);
    s = rand_state();
    send(4'd13, s, 1'b0);
    collect(4'd13, s, 1'b1);
    s = rand_state();
    send(4'd15, s, 1'b0);
    collect(4'd15, s, 1'b1);

    // random legal requests
    for (int n = 0; n < 6; n++) begin
      r = 4'($urandom_range(1, 12));
      s = rand_state();
      send(r, s, 1'b0);
      collect(r, s, 1'b1);
    end

    // backpressure: hold result 5 cycles, then release with a new request
    r = 4'($urandom_range(1, 12));
    s = rand_state();
    send(r, s, 1'b0);
    collect(r, s, 1'b0);
    exp_s = model_perm(s, int'(r));
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("bp_valid_u%0d", unroll_of(d)), 320'(out_valid[d]), 320'd1);
        chk($sformatf("bp_in_ready_u%0d", unroll_of(d)), 320'(in_ready[d]), 320'd0);
        chk($sformatf("bp_hold_u%0d", unroll_of(d)), dut_out(d), exp_s);
      end
    end
    r2 = 4'($urandom_range(1, 12));
    s2 = rand_state();
    send(r2, s2, 1'b1);
    collect(r2, s2, 1'b1);

    // reset during BUSY aborts the permutation
    s = rand_state();
    send(4'd12, s, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("abort_in_ready_u%0d", unroll_of(d)), 320'(in_ready[d]), 320'd1);
      chk($sformatf("abort_valid_u%0d", unroll_of(d)), 320'(out_valid[d]), 320'd0);
      chk($sformatf("abort_busy_u%0d", unroll_of(d)), 320'(busy[d]), 320'd0);
      chk($sformatf("abort_err_u%0d", unroll_of(d)), 320'(out_err[d]), 320'd0);
      chk($sformatf("abort_state_u%0d", unroll_of(d)), dut_out(d), 320'd0);
      stale[d] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) stale[d] |= out_valid[d];
    end
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("abort_no_stale_valid_u%0d", unroll_of(d)), 320'(stale[d]), 320'd0);

    // normal operation resumes after the abort
    r = 4'($urandom_range(1, 12));
    s = rand_state();
    send(r, s, 1'b0);
    collect(r, s, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
